// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier for signed operands.
// Each RUN cycle performs one Booth recode/add/shift step. The product is
// registered into RES when the last step completes, and done pulses for
// one cycle while in DONE.
//
// state | meaning
// IDLE  | waiting for start; RES holds the last product
// RUN   | one Booth step per cycle, r_size steps in total
// DONE  | done pulse; RES carries the new product
module booth_multiplier #(
  parameter int m_size   = 4,
  parameter int r_size   = 4,
  parameter int res_size = m_size + r_size
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [m_size-1:0]   M,
  input  logic signed [r_size-1:0]   R,
  output logic                       busy,
  output logic                       done,
  output logic signed [res_size-1:0] RES
);

  localparam int cnt_w = $clog2(r_size + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t              state_q, state_d;
  logic [m_size-1:0]   m_q, m_d;
  // The accumulator is one bit wider than M so that subtracting the most
  // negative multiplicand cannot overflow.
  logic [m_size:0]     a_q, a_d;
  logic [r_size-1:0]   q_q, q_d;
  logic                q1_q, q1_d;
  logic [cnt_w-1:0]    cnt_q, cnt_d;
  logic [res_size-1:0] res_q, res_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [m_size:0]          m_ext;
  logic [m_size:0]          a_sum;
  logic [m_size+r_size+1:0] sh;

  // Next-state, datapath step and registered-output decode.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    m_ext   = {m_q[m_size-1], m_q};
    a_sum   = a_q;
    sh      = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          m_d     = M;
          a_d     = '0;
          q_d     = R;
          q1_d    = 1'b0;
          cnt_d   = cnt_w'(r_size);
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        case ({q_q[0], q1_q})
          2'b01:   a_sum = a_q + m_ext;
          2'b10:   a_sum = a_q - m_ext;
          default: a_sum = a_q;
        endcase
        // Arithmetic shift of {A, Q, q_1}: the A sign bit is replicated.
        sh    = {a_sum[m_size], a_sum, q_q};
        a_d   = sh[m_size+r_size+1:r_size+1];
        q_d   = sh[r_size:1];
        q1_d  = sh[0];
        cnt_d = cnt_q - cnt_w'(1);
        if (cnt_q == cnt_w'(1)) begin
          res_d   = sh[res_size:1];
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Busy and done are registered from the state being entered.
  always_comb begin
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign RES  = res_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier (m_size = r_size = 4).
// Stimulus pushes expected products; a monitor pops one on every done pulse.
module tb_booth_multiplier;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic signed [3:0] M = '0;
  logic signed [3:0] R = '0;
  logic              busy;
  logic              done;
  logic signed [7:0] RES;

  int total = 0;
  int bad   = 0;

  logic signed [7:0] exp_q[$];

  booth_multiplier #(.m_size(4), .r_size(4), .res_size(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .M    (M),
    .R    (R),
    .busy (busy),
    .done (done),
    .RES  (RES)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected product.
  initial begin
    logic signed [7:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got RES %0d expected no done at %0t", RES, $time);
        end else begin
          e = exp_q.pop_front();
          chk("res", int'(RES), int'(e));
        end
      end
    end
  end

  // Bounded wait for the next done pulse, sampled at negedge.
  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk(name, int'(seen), 1);
  endtask

  // One operation from IDLE: checks busy length, done pulse width and,
  // optionally, that RES holds its previous value until completion.
  task automatic run_op(input logic signed [3:0] m, input logic signed [3:0] r,
                        input logic signed [7:0] exp, input bit chk_hold,
                        input logic signed [7:0] hold_v);
    int busy_n;
    bit seen;
    @(negedge clk);
    M = m;
    R = r;
    start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    start = 1'b0;
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (chk_hold) chk("hold_res", int'(RES), int'(hold_v));
        @(negedge clk);
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("busy_cycles", busy_n, 4);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
  endtask

  logic signed [3:0] dm [8] = '{4'sd1, 4'sd1, -4'sd1, -4'sd1, -4'sd8, 4'sd7, -4'sd8, 4'sd7};
  logic signed [3:0] dr [8] = '{4'sd2, -4'sd2, 4'sd2, -4'sd2, -4'sd8, -4'sd8, 4'sd7, 4'sd7};
  logic signed [7:0] dp [8] = '{8'sd2, -8'sd2, -8'sd2, 8'sd2, 8'sd64, -8'sd56, -8'sd56, 8'sd49};

  initial begin
    int done_n;

    // Reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_res", int'(RES), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;
    run_op(4'sd0, 4'sd0, 8'sd0, 1'b0, 8'sd0);

    // Directed signs and extremes
    for (int i = 0; i < 8; i++) run_op(dm[i], dr[i], dp[i], 1'b0, 8'sd0);

    // Exhaustive sweep
    for (int mi = -8; mi < 8; mi++)
      for (int ri = -8; ri < 8; ri++)
        run_op(4'(mi), 4'(ri), 8'(mi * ri), 1'b0, 8'sd0);

    // Handshake: start held high through RUN/DONE is only taken in IDLE
    @(negedge clk);
    M = 4'sd3;
    R = 4'sd3;
    start = 1'b1;
    exp_q.push_back(8'sd9);
    @(negedge clk);
    M = 4'sd5;
    R = 4'sd5;
    exp_q.push_back(8'sd25);
    wait_done("hs_first_done");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("hs_second_busy", int'(busy), 1);
    wait_done("hs_second_done");
    @(negedge clk);

    // Reset on the second RUN edge aborts the operation
    M = 4'sd7;
    R = 4'sd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_res", int'(RES), 0);
    done_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) done_n++;
    end
    chk("abort_no_done", done_n, 0);
    run_op(4'sd2, 4'sd3, 8'sd6, 1'b0, 8'sd0);

    // RES holds the previous product while the next runs
    run_op(4'sd5, -4'sd3, -8'sd15, 1'b0, 8'sd0);
    run_op(4'sd2, 4'sd2, 8'sd4, 1'b1, -8'sd15);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
